// File: rtl/fht_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// fht_addr_gen_pkg
//   Shared definitions for the FHT address generator:
//     - default transform size and pipeline latencies
//     - sequencer FSM state encoding
//     - small width helper
//   No ports (package).
// -----------------------------------------------------------------------------
package fht_addr_gen_pkg;

  // Default transform length exponent (N = 2**FHT_LOG2_N).
  localparam int FHT_LOG2_N  = 4;
  // Data-RAM / twiddle-ROM read latency in cycles.
  localparam int FHT_RAM_LAT = 1;
  // fht_but latency (sum_mul register + output register); must track fht_but.
  localparam int FHT_BUT_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fht_state_t;

  // Bit width able to index 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fht_addr_gen_delay_line.sv
// -----------------------------------------------------------------------------
// fht_addr_gen_delay_line
//   Reset-clearable shift register of DEPTH stages, WIDTH bits each.
//   Carries {wr_en, wr_bank, wr_addr_0, wr_addr_1} from read issue to the
//   point where the butterfly produces its outputs.
// Ports:
//   iCLK    in   1       clock
//   iRESET  in   1       asynchronous reset, active low (clears every stage)
//   d       in   WIDTH   value entering the line
//   q       out  WIDTH   value delayed by exactly DEPTH cycles
// DEPTH must be at least 1.
// -----------------------------------------------------------------------------
module fht_addr_gen_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // chain[i] feeds stage i; chain[DEPTH] is the line output.
  logic [WIDTH-1:0] chain [DEPTH+1];

  assign chain[0] = d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic [WIDTH-1:0] tap_reg;

      always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
          tap_reg <= '0;
        end else begin
          tap_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = tap_reg;
    end
  endgenerate

  assign q = chain[DEPTH];

endmodule

// File: rtl/fht_addr_gen.sv
// -----------------------------------------------------------------------------
// fht_addr_gen
//   Upstream sequencer for fht_but. Runs LOG2_N radix-2 Hartley stages over a
//   ping-pong RAM pair: per cycle it issues three operand read addresses
//   (X0/X1/X2) and one twiddle-ROM index, and delays the matching write
//   addresses/enable by D = RAM_LAT + BUT_LAT so they line up with Y0/Y1.
//
// Ports:
//   iCLK        in   1          clock
//   iRESET      in   1          asynchronous reset, active low
//   iSTART      in   1          start request, sampled in IDLE only
//   oBUSY       out  1          high in RUN, DRAIN and DONE
//   oDONE       out  1          one-cycle pulse: transform complete
//   oRD_EN      out  1          read-issue strobe
//   oRD_BANK    out  1          bank to read (= stage[0])
//   oRD_ADDR_0  out  LOG2_N     X0 address
//   oRD_ADDR_1  out  LOG2_N     X1 address
//   oRD_ADDR_2  out  LOG2_N     X2 address
//   oTW_ADDR    out  LOG2_N-1   twiddle-ROM index
//   oWR_EN      out  1          write strobe, aligned with fht_but outputs
//   oWR_BANK    out  1          bank to write (= ~read bank of issuing stage)
//   oWR_ADDR_0  out  LOG2_N     Y0 address
//   oWR_ADDR_1  out  LOG2_N     Y1 address
//   oSTAGE      out  STAGE_W    current stage index
//
// Build option:
//   FHT_BITREV_EN  defined: stage-0 read addresses are bit-reversed over
//                  LOG2_N bits (input stored in natural order).
//                  undefined: no reversal (input already bit-reversed).
// -----------------------------------------------------------------------------
module fht_addr_gen
  import fht_addr_gen_pkg::*;
#(
  parameter  int LOG2_N  = FHT_LOG2_N,
  parameter  int RAM_LAT = FHT_RAM_LAT,
  parameter  int BUT_LAT = FHT_BUT_LAT,
  localparam int STAGE_W = clog2_min1(LOG2_N)
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iSTART,
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oRD_EN,
  output logic                oRD_BANK,
  output logic [LOG2_N-1:0]   oRD_ADDR_0,
  output logic [LOG2_N-1:0]   oRD_ADDR_1,
  output logic [LOG2_N-1:0]   oRD_ADDR_2,
  output logic [LOG2_N-2:0]   oTW_ADDR,
  output logic                oWR_EN,
  output logic                oWR_BANK,
  output logic [LOG2_N-1:0]   oWR_ADDR_0,
  output logic [LOG2_N-1:0]   oWR_ADDR_1,
  output logic [STAGE_W-1:0]  oSTAGE
);

  localparam int D       = RAM_LAT + BUT_LAT;
  localparam int ISSUE_W = LOG2_N - 1;          // counts N/2 issues per stage
  localparam int DRAIN_W = clog2_min1(D);
  localparam int DL_W    = 2 + 2 * LOG2_N;

  localparam logic [ISSUE_W-1:0] ISSUE_LAST = '1;   // N/2 - 1
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2_N - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(D - 1);

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  fht_state_t          state_reg, state_next;
  logic [STAGE_W-1:0]  stage_reg, stage_next;
  logic [ISSUE_W-1:0]  issue_reg, issue_next;
  logic [DRAIN_W-1:0]  drain_reg, drain_next;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_reg <= ST_IDLE;
      stage_reg <= '0;
      issue_reg <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      issue_reg <= issue_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    issue_next = issue_reg;
    drain_next = drain_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (iSTART) begin
          state_next = ST_RUN;
          stage_next = '0;
          issue_next = '0;
        end
      end

      ST_RUN: begin
        if (issue_reg == ISSUE_LAST) begin
          state_next = ST_DRAIN;
          issue_next = '0;
          drain_next = '0;
        end else begin
          issue_next = issue_reg + 1'b1;
        end
      end

      // Wait D cycles so the stage's last write lands before the next
      // stage reads that bank.
      ST_DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          drain_next = '0;
          if (stage_reg == STAGE_LAST) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_RUN;
            stage_next = stage_reg + 1'b1;
          end
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        stage_next = '0;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address arithmetic
  //   The issue counter j enumerates (block, k) with k in the low s bits and
  //   the block number above them. Inserting a zero bit at position s yields
  //   b + k directly, since block bases are multiples of 2h.
  // ---------------------------------------------------------------------------
  logic                run;
  logic [LOG2_N-1:0]   issue_ext;
  logic [LOG2_N-1:0]   half_span;     // h = 2**s
  logic [LOG2_N-1:0]   low_mask;      // h - 1
  logic [LOG2_N-1:0]   k_val;
  logic [LOG2_N-1:0]   base_val;
  logic [LOG2_N-1:0]   x0, x1, x2;
  logic [LOG2_N-1:0]   x0_rd, x1_rd, x2_rd;
  logic [STAGE_W-1:0]  tw_shift;
  logic [ISSUE_W-1:0]  tw_val;

  assign run = (state_reg == ST_RUN);

  always_comb begin
    issue_ext = {1'b0, issue_reg};
    half_span = LOG2_N'(1) << stage_reg;
    low_mask  = half_span - 1'b1;
    k_val     = issue_ext & low_mask;
    base_val  = (issue_ext & ~low_mask) << 1;
    x0        = base_val | k_val;
    x1        = x0 | half_span;
    // k == 0 pairs X1 with itself (cos = 1, sin = 0). In the last stage
    // 2h == N wraps to 0, so the mod-N difference still gives N - k.
    if (k_val == '0) begin
      x2 = x1;
    end else begin
      x2 = base_val + (half_span << 1) - k_val;
    end
    tw_shift = STAGE_LAST - stage_reg;
    // k < h, so k fits in LOG2_N-1 bits and the shifted index never overflows.
    tw_val   = k_val[ISSUE_W-1:0] << tw_shift;
  end

`ifdef FHT_BITREV_EN
  logic [LOG2_N-1:0] x0_rev, x1_rev, x2_rev;
  logic              rev_sel;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2_N; gi++) begin : g_bitrev
      assign x0_rev[gi] = x0[LOG2_N-1-gi];
      assign x1_rev[gi] = x1[LOG2_N-1-gi];
      assign x2_rev[gi] = x2[LOG2_N-1-gi];
    end
  endgenerate

  // Only stage 0 reads the naturally ordered input.
  assign rev_sel = (stage_reg == '0);
  assign x0_rd   = rev_sel ? x0_rev : x0;
  assign x1_rd   = rev_sel ? x1_rev : x1;
  assign x2_rd   = rev_sel ? x2_rev : x2;
`else
  assign x0_rd = x0;
  assign x1_rd = x1;
  assign x2_rd = x2;
`endif

  // ---------------------------------------------------------------------------
  // Read-side outputs (forced to zero outside RUN)
  // ---------------------------------------------------------------------------
  assign oRD_EN     = run;
  assign oRD_BANK   = run & stage_reg[0];
  assign oRD_ADDR_0 = run ? x0_rd  : '0;
  assign oRD_ADDR_1 = run ? x1_rd  : '0;
  assign oRD_ADDR_2 = run ? x2_rd  : '0;
  assign oTW_ADDR   = run ? tw_val : '0;

  assign oBUSY  = (state_reg != ST_IDLE);
  assign oDONE  = (state_reg == ST_DONE);
  assign oSTAGE = stage_reg;

  // ---------------------------------------------------------------------------
  // Write-side: natural-order addresses delayed by D cycles.
  // Bank is gated by run so the line carries all-zero when idle.
  // ---------------------------------------------------------------------------
  logic [DL_W-1:0] wr_pipe_d, wr_pipe_q;

  assign wr_pipe_d = {run,
                      run & ~stage_reg[0],
                      run ? x0 : LOG2_N'(0),
                      run ? x1 : LOG2_N'(0)};

  fht_addr_gen_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (D)
  ) u_wr_delay (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .d      (wr_pipe_d),
    .q      (wr_pipe_q)
  );

  assign {oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1} = wr_pipe_q;

endmodule

// File: tb/tb_fht_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_fht_addr_gen
//   Directed bench for fht_addr_gen at LOG2_N=4, RAM_LAT=1, BUT_LAT=2 (D=3).
//   Cycle c is the interval after clock edge c-1; iSTART is held during
//   cycle 0. Outputs are sampled on the falling edge inside each cycle.
//   Honours FHT_BITREV_EN for the stage-0 read-address expectations.
// -----------------------------------------------------------------------------
module tb_fht_addr_gen;

  localparam int NCYC = 56;

`ifdef FHT_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  logic       iCLK = 1'b0;
  logic       iRESET = 1'b0;
  logic       iSTART = 1'b0;
  logic       oBUSY, oDONE, oRD_EN, oRD_BANK, oWR_EN, oWR_BANK;
  logic [3:0] oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oWR_ADDR_0, oWR_ADDR_1;
  logic [2:0] oTW_ADDR;
  logic [1:0] oSTAGE;

  fht_addr_gen #(.LOG2_N(4), .RAM_LAT(1), .BUT_LAT(2)) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iSTART     (iSTART),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE),
    .oRD_EN     (oRD_EN),
    .oRD_BANK   (oRD_BANK),
    .oRD_ADDR_0 (oRD_ADDR_0),
    .oRD_ADDR_1 (oRD_ADDR_1),
    .oRD_ADDR_2 (oRD_ADDR_2),
    .oTW_ADDR   (oTW_ADDR),
    .oWR_EN     (oWR_EN),
    .oWR_BANK   (oWR_BANK),
    .oWR_ADDR_0 (oWR_ADDR_0),
    .oWR_ADDR_1 (oWR_ADDR_1),
    .oSTAGE     (oSTAGE)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Recorded outputs of one run
  // ---------------------------------------------------------------------------
  logic       s_rd_en [NCYC];
  logic       s_rd_bank [NCYC];
  logic [3:0] s_a0 [NCYC];
  logic [3:0] s_a1 [NCYC];
  logic [3:0] s_a2 [NCYC];
  logic [2:0] s_tw [NCYC];
  logic       s_wr_en [NCYC];
  logic       s_wr_bank [NCYC];
  logic [3:0] s_w0 [NCYC];
  logic [3:0] s_w1 [NCYC];
  logic [1:0] s_stage [NCYC];
  logic       s_busy [NCYC];
  logic       s_done [NCYC];

  function automatic logic [30:0] pack_now();
    return {oRD_EN, oRD_BANK, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oTW_ADDR,
            oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1, oSTAGE, oBUSY, oDONE};
  endfunction

  function automatic logic [30:0] pack_obs(input int c);
    return {s_rd_en[c], s_rd_bank[c], s_a0[c], s_a1[c], s_a2[c], s_tw[c],
            s_wr_en[c], s_wr_bank[c], s_w0[c], s_w1[c], s_stage[c], s_busy[c], s_done[c]};
  endfunction

  // Sample cycles 0..NCYC-1; iSTART high in cycle 0 and in pulse cycles p1/p2.
  task automatic record_run(input int p1, input int p2);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge iCLK);
      s_rd_en[c] = oRD_EN;     s_rd_bank[c] = oRD_BANK;
      s_a0[c] = oRD_ADDR_0;    s_a1[c] = oRD_ADDR_1;   s_a2[c] = oRD_ADDR_2;
      s_tw[c] = oTW_ADDR;      s_wr_en[c] = oWR_EN;    s_wr_bank[c] = oWR_BANK;
      s_w0[c] = oWR_ADDR_0;    s_w1[c] = oWR_ADDR_1;   s_stage[c] = oSTAGE;
      s_busy[c] = oBUSY;       s_done[c] = oDONE;
      iSTART = (c == 0) || (c == p1) || (c == p2);
    end
    iSTART = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference issue list built from the nested (b, k) loops
  // ---------------------------------------------------------------------------
  int m_a0 [32], m_a1 [32], m_a2 [32], m_tw [32], m_w0 [32], m_w1 [32], m_st [32];

  function automatic int bitrev4(input int v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (((v >> i) & 1) != 0) r |= 1 << (3 - i);
    return r;
  endfunction

  function automatic int rb(input int v);
    return BITREV ? bitrev4(v) : v;
  endfunction

  task automatic build_model();
    int idx = 0;
    for (int s = 0; s < 4; s++) begin
      int h = 1 << s;
      for (int b = 0; b < 16; b += 2 * h) begin
        for (int k = 0; k < h; k++) begin
          m_w0[idx] = b + k;
          m_w1[idx] = b + h + k;
          m_a0[idx] = b + k;
          m_a1[idx] = b + h + k;
          m_a2[idx] = (k == 0) ? (b + h) : ((b + 2 * h - k) % 16);
          m_tw[idx] = k << (3 - s);
          m_st[idx] = s;
          if (s == 0) begin
            m_a0[idx] = rb(m_a0[idx]);
            m_a1[idx] = rb(m_a1[idx]);
            m_a2[idx] = rb(m_a2[idx]);
          end
          idx++;
        end
      end
    end
  endtask

  function automatic bit in_ranges(input int c, input int off);
    for (int s = 0; s < 4; s++)
      if (c >= 1 + 11 * s + off && c <= 8 + 11 * s + off) return 1'b1;
    return 1'b0;
  endfunction

  // Timing patterns plus every issue/write against the reference list.
  task automatic check_run(input string tag);
    int bad_rd = 0, bad_wr = 0, bad_busy = 0, bad_done = 0, n_rd = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (s_rd_en[c] !== in_ranges(c, 0)) bad_rd++;
      if (s_wr_en[c] !== in_ranges(c, 3)) bad_wr++;
      if (s_busy[c] !== (c >= 1 && c <= 45)) bad_busy++;
      if (s_done[c] !== (c == 45)) bad_done++;
      if (s_rd_en[c] === 1'b1) n_rd++;
    end
    check({tag, " rd_en_pattern_bad_cycles"}, 64'(bad_rd), 64'd0);
    check({tag, " wr_en_pattern_bad_cycles"}, 64'(bad_wr), 64'd0);
    check({tag, " busy_pattern_bad_cycles"}, 64'(bad_busy), 64'd0);
    check({tag, " done_pattern_bad_cycles"}, 64'(bad_done), 64'd0);
    check({tag, " rd_en_count"}, 64'(n_rd), 64'd32);
    for (int i = 0; i < 32; i++) begin
      int c = 1 + 11 * (i / 8) + (i % 8);
      logic [63:0] act, exp;
      act = {s_rd_bank[c], s_a0[c], s_a1[c], s_a2[c], s_tw[c], s_stage[c],
             s_wr_en[c+3], s_wr_bank[c+3], s_w0[c+3], s_w1[c+3]};
      exp = {1'(m_st[i] % 2), 4'(m_a0[i]), 4'(m_a1[i]), 4'(m_a2[i]), 3'(m_tw[i]), 2'(m_st[i]),
             1'b1, 1'(1 - (m_st[i] % 2)), 4'(m_w0[i]), 4'(m_w1[i])};
      check($sformatf("%s issue_%0d_cyc_%0d", tag, i, c), act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Hand-computed spot vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int         cyc;
    logic [30:0] exp;
  } vec_t;

  function automatic vec_t row(input int cyc, input int rd_en, input int rd_bank,
                               input int a0, input int a1, input int a2, input int tw,
                               input int wr_en, input int wr_bank, input int w0, input int w1,
                               input int stage, input int busy, input int done);
    vec_t v;
    v.cyc = cyc;
    v.exp = {1'(rd_en), 1'(rd_bank), 4'(a0), 4'(a1), 4'(a2), 3'(tw),
             1'(wr_en), 1'(wr_bank), 4'(w0), 4'(w1), 2'(stage), 1'(busy), 1'(done)};
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    int bad_abort;

    //            cyc rd bk  a0      a1      a2      tw wr wb w0 w1  st by dn
    vecs[0]  = row( 0, 0, 0, 0,      0,      0,      0, 0, 0, 0, 0,  0, 0, 0);
    vecs[1]  = row( 1, 1, 0, rb(0),  rb(1),  rb(1),  0, 0, 0, 0, 0,  0, 1, 0);
    vecs[2]  = row( 2, 1, 0, rb(2),  rb(3),  rb(3),  0, 0, 0, 0, 0,  0, 1, 0);
    vecs[3]  = row( 4, 1, 0, rb(6),  rb(7),  rb(7),  0, 1, 1, 0, 1,  0, 1, 0);
    vecs[4]  = row( 5, 1, 0, rb(8),  rb(9),  rb(9),  0, 1, 1, 2, 3,  0, 1, 0);
    vecs[5]  = row( 9, 0, 0, 0,      0,      0,      0, 1, 1, 10, 11, 0, 1, 0);
    vecs[6]  = row(12, 1, 1, 0,      2,      2,      0, 0, 0, 0, 0,  1, 1, 0);
    vecs[7]  = row(13, 1, 1, 1,      3,      3,      4, 0, 0, 0, 0,  1, 1, 0);
    vecs[8]  = row(15, 1, 1, 5,      7,      7,      4, 1, 0, 0, 2,  1, 1, 0);
    vecs[9]  = row(24, 1, 0, 1,      5,      7,      2, 0, 0, 0, 0,  2, 1, 0);
    vecs[10] = row(26, 1, 0, 3,      7,      5,      6, 1, 1, 0, 4,  2, 1, 0);
    vecs[11] = row(37, 1, 1, 3,      11,     13,     3, 1, 0, 0, 8,  3, 1, 0);
    vecs[12] = row(41, 1, 1, 7,      15,     9,      7, 1, 0, 4, 12, 3, 1, 0);
    vecs[13] = row(44, 0, 0, 0,      0,      0,      0, 1, 0, 7, 15, 3, 1, 0);
    vecs[14] = row(45, 0, 0, 0,      0,      0,      0, 0, 0, 0, 0,  3, 1, 1);
    vecs[15] = row(46, 0, 0, 0,      0,      0,      0, 0, 0, 0, 0,  0, 0, 0);

    build_model();

    // Reset state while iRESET is held low.
    repeat (3) @(negedge iCLK);
    check("reset_outputs", 64'(pack_now()), 64'd0);
    iRESET = 1'b1;

    // Run A: plain start.
    record_run(-1, -1);
    for (int i = 0; i < 16; i++) begin
      $display("row %0d cyc %0d: got %h expect %h", i, vecs[i].cyc, pack_obs(vecs[i].cyc), vecs[i].exp);
      check($sformatf("vec_row_%0d_cyc_%0d", i, vecs[i].cyc), 64'(pack_obs(vecs[i].cyc)), 64'(vecs[i].exp));
    end
    check_run("runA");

    // Run B: extra iSTART pulses while busy must be ignored.
    record_run(5, 30);
    check_run("runB");

    // Abort mid-operation: reset during cycle 20 (stage 1 drain).
    @(negedge iCLK);
    iSTART = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge iCLK);
      iSTART = 1'b0;
    end
    check("abort_pre_busy_wr", 64'({oBUSY, oWR_EN, oSTAGE}), 64'({1'b1, 1'b1, 2'd1}));
    iRESET = 1'b0;
    @(negedge iCLK);
    check("abort_outputs_zero", 64'(pack_now()), 64'd0);
    @(negedge iCLK);
    iRESET = 1'b1;
    bad_abort = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge iCLK);
      if (oDONE !== 1'b0 || oBUSY !== 1'b0 || oWR_EN !== 1'b0) bad_abort++;
    end
    $display("abort: %0d cycles with activity after release", bad_abort);
    check("abort_no_done_busy_cycles", 64'(bad_abort), 64'd0);

    // Restart after abort begins again at stage 0.
    record_run(-1, -1);
    check("restart_first_issue", 64'(pack_obs(1)), 64'(vecs[1].exp));
    check_run("restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
